// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode path.
package fetch_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int FQ_XLEN  = 32;

    localparam logic [FQ_XLEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fq_entry_t                wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fq_entry_t                rdata
);

    fq_entry_t mem [DEPTH];

    // Storage is cleared on reset so the head outputs read as zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// FIFO instruction buffer between fetch and decode with flush and back-pressure.
// Optional macro FETCH_QUEUE_BYPASS_EN: forward FE straight to decode when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = FQ_XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fe_valid,
    input  logic [XLEN-1:0]        fe_pc,
    input  logic [XLEN-1:0]        fe_inst,
    output logic                   fe_stall,
    input  logic                   flush,
    output logic                   id_valid,
    output logic [XLEN-1:0]        id_pc,
    output logic [XLEN-1:0]        id_inst,
    input  logic                   id_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;
    fq_entry_t        wr_entry;
    fq_entry_t        rd_entry;

    assign empty    = (count == '0);
    assign fe_stall = (count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && fe_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction taken by decode in the same cycle is never stored.
    assign push = fe_valid && !fe_stall && !flush && !(bypass && id_ready);
    assign pop  = !empty && id_ready && !flush;

    assign id_valid = !empty || bypass;
    assign id_pc    = bypass ? fe_pc   : rd_entry.pc;
    assign id_inst  = bypass ? fe_inst : rd_entry.inst;

    assign wr_entry.pc   = fe_pc;
    assign wr_entry.inst = fe_inst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    fetch_queue_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .raddr(rd_ptr),
        .rdata(rd_entry)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: per-cycle vector table plus a PC scoreboard.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fe_valid;
    logic [31:0] fe_pc;
    logic [31:0] fe_inst;
    logic        fe_stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .fe_valid(fe_valid),
        .fe_pc   (fe_pc),
        .fe_inst (fe_inst),
        .fe_stall(fe_stall),
        .flush   (flush),
        .id_valid(id_valid),
        .id_pc   (id_pc),
        .id_inst (id_inst),
        .id_ready(id_ready),
        .count   (count)
    );

    typedef struct {
        logic        fe_valid;
        logic [31:0] fe_pc;
        logic        flush;
        logic        id_ready;
        int          exp_count;
        logic        exp_valid;
        logic        exp_stall;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic fl,
                                input logic rdy, input int c, input logic ev, input logic es);
        vec_t r;
        r.fe_valid = v; r.fe_pc = pc; r.flush = fl; r.id_ready = rdy;
        r.exp_count = c; r.exp_valid = ev; r.exp_stall = es;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
        fe_valid = v;
        fe_pc    = pc;
        fe_inst  = inst_of(pc);
        flush    = fl;
        id_ready = rdy;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        // fill, refused push while full (even with a pop), drain
        vecs.push_back(mk(1, 32'h00, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h04, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h08, 0, 0, 2, 1, 0));
        vecs.push_back(mk(1, 32'h0C, 0, 0, 3, 1, 0));
        vecs.push_back(mk(1, 32'h10, 0, 0, 4, 1, 1));
        vecs.push_back(mk(1, 32'h10, 0, 1, 4, 1, 1));
        vecs.push_back(mk(0, 32'h00, 0, 1, 3, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 2, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0));
        // wrap-around: back-to-back push+pop, pointers cross the wrap
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1, 32'(i * 4), 0, 1, (i == 0) ? 0 : 1, (i != 0), 0));
        end
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0));
        // flush with simultaneous push and pop, then first post-redirect push
        vecs.push_back(mk(1, 32'h40, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h44, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h48, 0, 0, 2, 1, 0));
        vecs.push_back(mk(1, 32'h7C, 1, 1, 3, 1, 0));
        vecs.push_back(mk(1, 32'h08, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 32'h00, 0, 1, 0, 0, 0));
        // flush from full releases the stall
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h104, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 32'h108, 0, 0, 2, 1, 0));
        vecs.push_back(mk(1, 32'h10C, 0, 0, 3, 1, 0));
        vecs.push_back(mk(1, 32'h200, 1, 0, 4, 1, 1));
        vecs.push_back(mk(1, 32'h204, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 32'h000, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 32'h000, 0, 1, 0, 0, 0));

        repeat (2) @(posedge clk);
        #3;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(id_valid), 32'd0);
        chk("reset_stall", 32'(fe_stall), 32'd0);
        chk("reset_pc", id_pc, 32'd0);
        chk("reset_inst", id_inst, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            vec_t v;
            v = vecs[k];
            drive(v.fe_valid, v.fe_pc, v.flush, v.id_ready);
            #2;
            chk($sformatf("v%0d_count", k), 32'(count), 32'(v.exp_count));
            chk($sformatf("v%0d_valid", k), 32'(id_valid), 32'(v.exp_valid));
            chk($sformatf("v%0d_stall", k), 32'(fe_stall), 32'(v.exp_stall));
            if (v.exp_valid && v.id_ready && !v.flush) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d_sb: pop with empty scoreboard", k);
                end else begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    chk($sformatf("v%0d_pop_pc", k), id_pc, e);
                    chk($sformatf("v%0d_pop_inst", k), id_inst, inst_of(e));
                end
            end
            if (v.flush) sb.delete();
            else if (v.fe_valid && !v.exp_stall) sb.push_back(v.fe_pc);
            @(posedge clk);
            #1;
        end
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // reset mid-stream: takes effect without a clock edge
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h304, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst_count", 32'(count), 32'd2);
        chk("pre_rst_pc", id_pc, 32'h300);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_pc", id_pc, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // empty queue, FE presents with decode ready
        drive(1'b1, 32'h7C, 1'b0, 1'b1);
        #2;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_same_valid", 32'(id_valid), 32'd1);
        chk("byp_same_pc", id_pc, 32'h7C);
        chk("byp_same_inst", id_inst, inst_of(32'h7C));
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("byp_next_count", 32'(count), 32'd0);
        chk("byp_next_valid", 32'(id_valid), 32'd0);
`else
        chk("nobyp_same_valid", 32'(id_valid), 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        chk("nobyp_next_valid", 32'(id_valid), 32'd1);
        chk("nobyp_next_pc", id_pc, 32'h7C);
        chk("nobyp_next_count", 32'(count), 32'd1);
        @(posedge clk); #1;
        chk("nobyp_drained", 32'(count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
